// File: rtl/ui_cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
package ui_cam_cfg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDelay,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StNext,
    StDone,
    StFail
  } seq_state_e;

  localparam logic [15:0] DelayMarkDefault = 16'hFFFF;

  // Self-clearing reset/clock registers never read back what was written.
  localparam int unsigned NumVerifySkip = 2;
  localparam logic [NumVerifySkip-1:0][15:0] VerifySkipAddr = {16'h3103, 16'h3008};

  function automatic int unsigned ms_cnt_w(input int unsigned clk_hz);
    int unsigned period;
    period = clk_hz / 1000;
    if (period < 2) return 1;
    return $clog2(period);
  endfunction

  function automatic logic verify_skip(input logic [15:0] addr);
    logic skip;
    skip = 1'b0;
    for (int i = 0; i < NumVerifySkip; i++) begin
      if (addr == VerifySkipAddr[i]) skip = 1'b1;
    end
    return skip;
  endfunction

endpackage

// File: rtl/ui_ms_tick.sv
// Millisecond tick generator; restart_i re-phases it so the first tick is 1 ms later.
module ui_ms_tick import ui_cam_cfg_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned Period = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int unsigned CntW = ms_cnt_w(CLK_HZ);
  localparam logic [CntW-1:0] LastCnt = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ui_cam_cfg_seq.sv
// Walks a sensor register table and issues each entry as an I2C/SCCB write,
// with in-table ms delays, bounded NACK retry and optional read-back verify.
module ui_cam_cfg_seq import ui_cam_cfg_pkg::*; #(
  parameter int unsigned        ADDR_W     = 16,
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        IDX_W      = 9,
  parameter int unsigned        CLK_HZ     = 50_000_000,
  parameter int unsigned        MAX_RETRY  = 3,
  parameter int unsigned        VERIFY     = 0,
  parameter logic [ADDR_W-1:0]  DELAY_MARK = ADDR_W'(DelayMarkDefault)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic [IDX_W-1:0]         reg_index_o,
  input  logic [ADDR_W+DATA_W-1:0] reg_data_i,
  input  logic [IDX_W-1:0]         reg_size_i,
  output logic                     iic_req_o,
  output logic                     iic_rd_o,
  output logic [ADDR_W-1:0]        iic_addr_o,
  output logic [DATA_W-1:0]        iic_wdata_o,
  input  logic                     iic_ack_i,
  input  logic                     iic_done_i,
  input  logic                     iic_err_i,
  input  logic [DATA_W-1:0]        iic_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [IDX_W-1:0]         err_index_o
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  seq_state_e state_q, state_d;

  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  size_q, size_d;
  logic [IDX_W-1:0]  err_index_q, err_index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              tick, restart;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              skip_verify;
  logic              wr_resp, rd_resp, wr_ok, rd_ok, attempt_bad;

  assign fetch_addr  = reg_data_i[ADDR_W+DATA_W-1:DATA_W];
  assign fetch_data  = reg_data_i[DATA_W-1:0];
  assign skip_verify = verify_skip(16'(addr_q));

  // A completion may coincide with the ack cycle, so it is honoured in the request state too.
  assign wr_resp = iic_done_i &&
                   ((state_q == StWrWait) || ((state_q == StWrReq) && iic_ack_i));
  assign rd_resp = iic_done_i &&
                   ((state_q == StRdWait) || ((state_q == StRdReq) && iic_ack_i));
  assign wr_ok       = wr_resp && !iic_err_i;
  assign rd_ok       = rd_resp && !iic_err_i && (iic_rdata_i == data_q);
  assign attempt_bad = (wr_resp && iic_err_i) || (rd_resp && !rd_ok);

  ui_ms_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    size_d      = size_q;
    err_index_d = err_index_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ms_cnt_d    = ms_cnt_q;
    retry_d     = retry_q;
    done_d      = done_q;
    error_d     = error_q;
    restart     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          index_d     = '0;
          size_d      = reg_size_i;
          retry_d     = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          if (reg_size_i == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        addr_d   = fetch_addr;
        data_d   = fetch_data;
        ms_cnt_d = '0;
        if (fetch_addr == DELAY_MARK) begin
          state_d = StDelay;
          restart = 1'b1;
        end else begin
          state_d = StWrReq;
        end
      end
      StDelay: begin
        if (data_q == '0) begin
          state_d = StNext;
        end else if (tick) begin
          if (ms_cnt_q == data_q - 1'b1) state_d = StNext;
          else                           ms_cnt_d = ms_cnt_q + 1'b1;
        end
      end
      StWrReq:  if (iic_ack_i) state_d = StWrWait;
      StRdReq:  if (iic_ack_i) state_d = StRdWait;
      StWrWait: ;
      StRdWait: ;
      StNext: begin
        retry_d = '0;
        if (index_q == size_q - IdxOne) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (wr_ok) state_d = ((VERIFY != 0) && !skip_verify) ? StRdReq : StNext;
    if (rd_ok) state_d = StNext;
    // Retry counter only advances below the limit, so it saturates there.
    if (attempt_bad) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 1'b1;
        state_d = StWrReq;
      end else begin
        state_d     = StFail;
        error_d     = 1'b1;
        err_index_d = index_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      index_q     <= '0;
      size_q      <= '0;
      err_index_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      ms_cnt_q    <= '0;
      retry_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      size_q      <= size_d;
      err_index_q <= err_index_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ms_cnt_q    <= ms_cnt_d;
      retry_q     <= retry_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign reg_index_o = index_q;
  assign iic_req_o   = (state_q == StWrReq) || (state_q == StRdReq);
  assign iic_rd_o    = (state_q == StRdReq) || (state_q == StRdWait);
  assign iic_addr_o  = addr_q;
  assign iic_wdata_o = data_q;
  assign busy_o      = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_index_o = err_index_q;

endmodule

// File: tb/tb_ui_cam_cfg_seq.sv
// Scoreboard bench: expected I2C transactions are queued by the stimulus and
// popped by a monitor at each accepted request; a behavioural master answers.
module tb_ui_cam_cfg_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [8:0]  reg_index_o;
  logic [23:0] reg_data_i;
  logic [8:0]  reg_size_i = '0;
  logic        iic_req_o, iic_rd_o;
  logic [15:0] iic_addr_o;
  logic [7:0]  iic_wdata_o;
  logic        iic_ack_i = 1'b0, iic_done_i = 1'b0, iic_err_i = 1'b0;
  logic [7:0]  iic_rdata_i = '0;
  logic        busy_o, done_o, error_o;
  logic [8:0]  err_index_o;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t        exp_q[$];
  int          rise_q[$];
  int          done_cyc_q[$];
  logic [23:0] tbl [16];
  logic [7:0]  mem [logic [15:0]];

  int n_cmp = 0, n_bad = 0, n_acc = 0, cyc = 0;
  int ack_lat = 2, done_lat = 2;
  logic [15:0] nack_addr = '0, bad_addr = '0;
  int nack_left = 0, bad_left = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign reg_data_i = tbl[reg_index_o[3:0]];

  ui_cam_cfg_seq #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .IDX_W     (9),
    .CLK_HZ    (1000),
    .MAX_RETRY (3),
    .VERIFY    (1),
    .DELAY_MARK(16'hFFFF)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .reg_index_o (reg_index_o),
    .reg_data_i  (reg_data_i),
    .reg_size_i  (reg_size_i),
    .iic_req_o   (iic_req_o),
    .iic_rd_o    (iic_rd_o),
    .iic_addr_o  (iic_addr_o),
    .iic_wdata_o (iic_wdata_o),
    .iic_ack_i   (iic_ack_i),
    .iic_done_i  (iic_done_i),
    .iic_err_i   (iic_err_i),
    .iic_rdata_i (iic_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_index_o (err_index_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, required event did not occur", name);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.rd = 1'b0; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic exp_rd(input logic [15:0] a);
    txn_t t;
    t.rd = 1'b1; t.addr = a; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic load_t1();
    tbl[0] = 24'h3103_11;
    tbl[1] = 24'h3008_82;
    tbl[2] = 24'h3017_ff;
    tbl[3] = 24'h3018_ff;
    reg_size_i = 9'd4;
  endtask

  task automatic start_pulse();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_seq(input string name);
    bit seen;
    seen = 1'b0;
    done_cyc_q.delete();
    rise_q.delete();
    start_pulse();
    for (int i = 0; i < 400; i++) begin
      #2;
      if (done_o || error_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!seen) fail_now(name);
  endtask

  // Behavioural I2C master: ack after ack_lat cycles, done done_lat cycles later.
  initial begin : master
    logic        m_rd;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    forever begin
      @(negedge clk_i);
      iic_ack_i  = 1'b0;
      iic_done_i = 1'b0;
      iic_err_i  = 1'b0;
      if (iic_req_o) begin
        m_rd   = iic_rd_o;
        m_addr = iic_addr_o;
        m_data = iic_wdata_o;
        repeat (ack_lat) @(negedge clk_i);
        iic_ack_i = 1'b1;
        if (done_lat != 0) begin
          @(negedge clk_i);
          iic_ack_i = 1'b0;
          repeat (done_lat - 1) @(negedge clk_i);
        end
        if (!m_rd) begin
          if (m_addr == nack_addr && nack_left > 0) begin
            iic_err_i = 1'b1;
            nack_left--;
          end else begin
            mem[m_addr] = m_data;
          end
        end else if (m_addr == bad_addr && bad_left > 0) begin
          iic_rdata_i = 8'h00;
          bad_left--;
        end else begin
          iic_rdata_i = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
        end
        iic_done_i = 1'b1;
        done_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin : monitor
    logic prev_req;
    txn_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      if (iic_req_o && !prev_req) rise_q.push_back(cyc);
      prev_req = iic_req_o;
      if (iic_req_o && iic_ack_i) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_txn: got rd=%0d addr=0x%0h, required no transaction",
                   iic_rd_o, iic_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("txn_rd", 32'(iic_rd_o), 32'(e.rd));
          check("txn_addr", 32'(iic_addr_o), 32'(e.addr));
          if (!e.rd) check("txn_wdata", 32'(iic_wdata_o), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, r1;
    bit seen;
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    check("rst_req", 32'(iic_req_o), 0);
    check("rst_rd", 32'(iic_rd_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_err_index", 32'(err_index_o), 0);
    check("rst_index", 32'(reg_index_o), 0);

    // Plain 4-entry table; the two self-clearing registers get no read-back.
    load_t1();
    ack_lat = 2; done_lat = 2;
    exp_wr(16'h3103, 8'h11);
    exp_wr(16'h3008, 8'h82);
    exp_wr(16'h3017, 8'hff); exp_rd(16'h3017);
    exp_wr(16'h3018, 8'hff); exp_rd(16'h3018);
    run_seq("t1_seq");
    check("t1_done", 32'(done_o), 1);
    check("t1_error", 32'(error_o), 0);
    check("t1_busy", 32'(busy_o), 0);
    check("t1_drained", exp_q.size(), 0);

    // 5 ms delay entry at one tick per cycle; done coincides with ack.
    tbl[0] = 24'h3008_82;
    tbl[1] = 24'hFFFF_05;
    tbl[2] = 24'h3008_01;
    reg_size_i = 9'd3;
    ack_lat = 1; done_lat = 0;
    exp_wr(16'h3008, 8'h82);
    exp_wr(16'h3008, 8'h01);
    run_seq("t2_seq");
    check("t2_done", 32'(done_o), 1);
    check("t2_req_count", rise_q.size(), 2);
    if (rise_q.size() >= 2 && done_cyc_q.size() >= 1) begin
      d0 = done_cyc_q[0];
      r1 = rise_q[1];
      check("t2_delay_gap", 32'(r1 - d0), 32'd10);
    end
    check("t2_drained", exp_q.size(), 0);

    // Two NACKs on entry 2 are absorbed by retries.
    load_t1();
    ack_lat = 2; done_lat = 2;
    nack_addr = 16'h3017; nack_left = 2;
    exp_wr(16'h3103, 8'h11);
    exp_wr(16'h3008, 8'h82);
    repeat (3) exp_wr(16'h3017, 8'hff);
    exp_rd(16'h3017);
    exp_wr(16'h3018, 8'hff); exp_rd(16'h3018);
    run_seq("t3_seq");
    check("t3_done", 32'(done_o), 1);
    check("t3_error", 32'(error_o), 0);
    check("t3_drained", exp_q.size(), 0);

    // Four NACKs exhaust the retries.
    nack_left = 4;
    exp_wr(16'h3103, 8'h11);
    exp_wr(16'h3008, 8'h82);
    repeat (4) exp_wr(16'h3017, 8'hff);
    run_seq("t4_seq");
    check("t4_error", 32'(error_o), 1);
    check("t4_done", 32'(done_o), 0);
    check("t4_err_index", 32'(err_index_o), 2);
    check("t4_busy", 32'(busy_o), 0);
    check("t4_drained", exp_q.size(), 0);
    nack_left = 0;

    // Read-back mismatch three times, then a good compare.
    tbl[0] = 24'h3008_01;
    tbl[1] = 24'h3034_1a;
    reg_size_i = 9'd2;
    bad_addr = 16'h3034; bad_left = 3;
    exp_wr(16'h3008, 8'h01);
    repeat (4) begin
      exp_wr(16'h3034, 8'h1a);
      exp_rd(16'h3034);
    end
    run_seq("t5_seq");
    check("t5_done", 32'(done_o), 1);
    check("t5_error", 32'(error_o), 0);
    check("t5_drained", exp_q.size(), 0);

    // Reset while entry 1 waits for completion; the late done must be ignored.
    load_t1();
    ack_lat = 2; done_lat = 3;
    exp_wr(16'h3103, 8'h11);
    exp_wr(16'h3008, 8'h82);
    n_acc = 0;
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (n_acc >= 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!seen) fail_now("t6_reach_entry1");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    check("t6_req_after_rst", 32'(iic_req_o), 0);
    check("t6_busy_after_rst", 32'(busy_o), 0);
    repeat (12) @(negedge clk_i);
    #2;
    check("t6_done_ignored", 32'(done_o), 0);
    check("t6_busy_idle", 32'(busy_o), 0);
    check("t6_index_zero", 32'(reg_index_o), 0);
    check("t6_drained", exp_q.size(), 0);
    exp_wr(16'h3103, 8'h11);
    exp_wr(16'h3008, 8'h82);
    exp_wr(16'h3017, 8'hff); exp_rd(16'h3017);
    exp_wr(16'h3018, 8'hff); exp_rd(16'h3018);
    run_seq("t6_restart");
    check("t6_restart_done", 32'(done_o), 1);
    check("t6_restart_drained", exp_q.size(), 0);

    // Empty table completes immediately with no transactions.
    reg_size_i = 9'd0;
    n_acc = 0;
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!seen) fail_now("t7_done_within_2");
    repeat (5) @(negedge clk_i);
    #2;
    check("t7_done", 32'(done_o), 1);
    check("t7_no_txn", n_acc, 0);
    check("t7_no_req", 32'(iic_req_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
